elastic_context_sequencer: RTL
==============================

// Module: elastic_context_sequencer
// PURPOSE
//  Per-PE context controller for an elastic ALU. Stores up to CONTEXT_DEPTH (op, const) entries.
//  Drives the ALU's op/const_data from the active entry and advances on each switch_context pulse.
//  Wraps over NUM contexts and counts loop iterations until the programmed count completes.
//  Sits between the global config loader and one ALU; gates the ALU via alu_enable.
// PARAMETERS
//  DATA_WIDTH            32  width of const_data / cfg_const
//  OPERATION_BIT_LENGTH  4   width of op field (0 = nop)
//  CONTEXT_DEPTH         8   number of context entries
//  CTX_ADDR_WIDTH        3   clog2(CONTEXT_DEPTH)
//  LOOP_WIDTH            16  iteration counter width
// PORTS
//  clk             in   1                     clock
//  reset_n         in   1                     async active-low reset
//  cfg_write       in   1                     write context entry (accepted in IDLE/DONE only)
//  cfg_addr        in   CTX_ADDR_WIDTH        entry index
//  cfg_op          in   OPERATION_BIT_LENGTH  entry opcode
//  cfg_const       in   DATA_WIDTH            entry constant
//  start           in   1                     pulse: begin sequencing
//  num_contexts    in   CTX_ADDR_WIDTH+1      contexts per iteration, 1..CONTEXT_DEPTH, sampled at start
//  num_iterations  in   LOOP_WIDTH            iterations; 0 = run forever, sampled at start
//  abort           in   1                     return to IDLE
//  switch_context  in   1                     from ALU: output transfer completed
//  op              out  OPERATION_BIT_LENGTH  to ALU
//  const_data      out  DATA_WIDTH            to ALU
//  alu_enable      out  1                     high only in RUN; gates ALU valid_input upstream
//  context_index   out  CTX_ADDR_WIDTH        active entry
//  busy            out  1                     state == RUN
//  done            out  1                     state == DONE
//  cfg_error       out  1                     1-cycle pulse on rejected command
// BEHAVIOUR
//  Reset: state=IDLE, op=0, const_data=0, context_index=0, iteration count=0, all flags 0; table cleared to nop/0.
//  States: IDLE -> RUN on valid start; RUN -> DONE on final wrap; RUN -> IDLE on abort; DONE -> RUN on valid start;
//   DONE -> IDLE on abort.
//  Valid start: state in {IDLE, DONE} and 1 <= num_contexts <= CONTEXT_DEPTH. Otherwise ignored and cfg_error=1.
//   Start while in RUN is ignored and flags cfg_error.
//  On a valid start edge: index<=0, iter<=0, op/const_data<=entry[0]; alu_enable high from the next cycle.
//  op/const_data are registered and equal entry[context_index] in RUN. Outside RUN: op=0, const_data=0.
//  switch_context in RUN: next index = (index == num_contexts-1) ? 0 : index+1.
//   op/const_data are updated on the same edge, so the ALU sees the new op in its next BEFORE_EXEC cycle.
//  Wrap (index == num_contexts-1 with switch) increments iter. If num_iterations != 0 and iter+1 == num_iterations:
//   go to DONE, index<=0, op<=0. Iteration counter saturates at all-ones when num_iterations=0.
//  switch_context outside RUN is ignored (no error).
//  abort has priority over switch_context and start on the same cycle. Index and iter are cleared.
//  cfg_write in IDLE/DONE: entry[cfg_addr] updated at the edge. cfg_write in RUN is ignored and flags cfg_error.
//   cfg_addr >= CONTEXT_DEPTH is ignored and flags cfg_error.
//  Same-cycle cfg_write + valid start in IDLE: the write lands first. If cfg_addr==0, entry[0] is presented with the new
//   value (write-through bypass).
//  Reset mid-RUN: immediate return to reset values. Table contents are lost.
// STRUCTURE
//  Shared package elastic_ctx_pkg:
//   - enum ctx_state_t {CTX_IDLE, CTX_RUN, CTX_DONE}
//   - struct ctx_entry_t {op, const_data}
//   - OP_NOP = 0
//  Sub-module elastic_context_table: CONTEXT_DEPTH x ctx_entry_t regfile.
//   - 1 sync write port, 1 async read port, async reset clear.
//  Top level holds the FSM, index and iteration counters, and the output registers.
// TESTING
//  1. Reset: op=0, const_data=0, busy=0, done=0, alu_enable=0.
//  2. Load entries {1,0},{5,7},{3,0}; start num_contexts=3, num_iterations=2; pulse switch 6x.
//     -> op seq 1,5,3,1,5,3. done=1 after the 6th pulse, op=0.
//  3. num_contexts=1, num_iterations=0; 100 switches.
//     -> op stays constant, index=0, never done, busy=1.
//  4. cfg_write in RUN and start with num_contexts=0 -> cfg_error pulse, table and state unchanged.
//  5. abort + switch_context in the same cycle mid-RUN -> IDLE, index=0, op=0, no advance.
//  6. Assert reset_n low mid-RUN at index 2 -> all outputs are at reset values asynchronously.
//     A valid restart after reset reads nop entries.

Source files
------------

// File: rtl/elastic_context_sequencer_pkg.sv
// rtl/elastic_context_sequencer_pkg.sv - shared types and sizes for the elastic context sequencer
package elastic_ctx_pkg;

    localparam int DATA_WIDTH           = 32;
    localparam int OPERATION_BIT_LENGTH = 4;
    localparam int CONTEXT_DEPTH        = 8;
    localparam int CTX_ADDR_WIDTH       = 3;
    localparam int LOOP_WIDTH           = 16;

    typedef enum logic [1:0] {
        CTX_IDLE = 2'd0,
        CTX_RUN  = 2'd1,
        CTX_DONE = 2'd2
    } ctx_state_t;

    typedef struct packed {
        logic [OPERATION_BIT_LENGTH-1:0] op;
        logic [DATA_WIDTH-1:0]           const_data;
    } ctx_entry_t;

    localparam logic [OPERATION_BIT_LENGTH-1:0] OP_NOP = '0;

endpackage

// File: rtl/elastic_context_sequencer_if.sv
// rtl/elastic_context_sequencer_if.sv - config loader / ALU side bundle of the context sequencer
interface elastic_context_sequencer_if
    import elastic_ctx_pkg::*;
();

    logic                            cfg_write;
    logic [CTX_ADDR_WIDTH-1:0]       cfg_addr;
    logic [OPERATION_BIT_LENGTH-1:0] cfg_op;
    logic [DATA_WIDTH-1:0]           cfg_const;
    logic                            start;
    logic [CTX_ADDR_WIDTH:0]         num_contexts;
    logic [LOOP_WIDTH-1:0]           num_iterations;
    logic                            abort;
    logic                            switch_context;

    logic [OPERATION_BIT_LENGTH-1:0] op;
    logic [DATA_WIDTH-1:0]           const_data;
    logic                            alu_enable;
    logic [CTX_ADDR_WIDTH-1:0]       context_index;
    logic                            busy;
    logic                            done;
    logic                            cfg_error;

    modport master (
        output cfg_write, cfg_addr, cfg_op, cfg_const, start, num_contexts,
               num_iterations, abort, switch_context,
        input  op, const_data, alu_enable, context_index, busy, done, cfg_error
    );

    modport slave (
        input  cfg_write, cfg_addr, cfg_op, cfg_const, start, num_contexts,
               num_iterations, abort, switch_context,
        output op, const_data, alu_enable, context_index, busy, done, cfg_error
    );

endinterface

// File: rtl/elastic_context_sequencer_table.sv
// rtl/elastic_context_sequencer_table.sv - context entry regfile, one sync write port, one async read port
module elastic_context_table
    import elastic_ctx_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en_i,
    input  logic [CTX_ADDR_WIDTH-1:0] wr_addr_i,
    input  ctx_entry_t                wr_entry_i,
    input  logic [CTX_ADDR_WIDTH-1:0] rd_addr_i,
    output ctx_entry_t                rd_entry_o
);

    ctx_entry_t mem_q [CONTEXT_DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CONTEXT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_entry_i;
        end
    end

    assign rd_entry_o = mem_q[rd_addr_i];

endmodule

// File: rtl/elastic_context_sequencer.sv
// rtl/elastic_context_sequencer.sv - per-PE context sequencer: FSM, index/iteration counters, ALU op registers
module elastic_context_sequencer
    import elastic_ctx_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    elastic_context_sequencer_if.slave bus
);

    localparam logic [CTX_ADDR_WIDTH:0] DEPTH_W = (CTX_ADDR_WIDTH+1)'(CONTEXT_DEPTH);

    ctx_state_t                      state_q, state_d;
    logic [CTX_ADDR_WIDTH-1:0]       idx_q, idx_d;
    logic [LOOP_WIDTH-1:0]           iter_q, iter_d;
    logic [LOOP_WIDTH-1:0]           niter_q, niter_d;
    logic [CTX_ADDR_WIDTH:0]         nctx_q, nctx_d;
    logic [OPERATION_BIT_LENGTH-1:0] op_q, op_d;
    logic [DATA_WIDTH-1:0]           const_q, const_d;
    logic                            err_q, err_d;

    logic                      idle_like, nctx_ok, addr_ok, wr_en, start_ok;
    logic                      run_switch, last, wrap, final_wrap;
    logic [LOOP_WIDTH-1:0]     iter_inc, iter_sat;
    logic [CTX_ADDR_WIDTH-1:0] rd_addr;
    ctx_entry_t                wr_entry, rd_entry, start_entry;

    assign idle_like  = (state_q != CTX_RUN);
    assign nctx_ok    = (bus.num_contexts != '0) && (bus.num_contexts <= DEPTH_W);
    assign addr_ok    = ({1'b0, bus.cfg_addr} < DEPTH_W);
    assign wr_en      = bus.cfg_write && idle_like && addr_ok;
    assign start_ok   = bus.start && !bus.abort && idle_like && nctx_ok;
    assign run_switch = (state_q == CTX_RUN) && bus.switch_context && !bus.abort;
    assign last       = ({1'b0, idx_q} == (nctx_q - 1'b1));
    assign wrap       = run_switch && last;
    assign iter_inc   = iter_q + 1'b1;
    assign iter_sat   = (iter_q == '1) ? iter_q : iter_inc;
    assign final_wrap = wrap && (niter_q != '0) && (iter_inc == niter_q);

    assign err_d = (bus.start && !bus.abort && !(idle_like && nctx_ok))
                 || (bus.cfg_write && (!idle_like || !addr_ok));

    // Read port looks one step ahead so the registered op lands with the index.
    assign rd_addr     = (start_ok || last) ? '0 : idx_q + 1'b1;
    assign wr_entry    = '{op: bus.cfg_op, const_data: bus.cfg_const};
    assign start_entry = (wr_en && bus.cfg_addr == '0) ? wr_entry : rd_entry;

    elastic_context_table u_table (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en_i    (wr_en),
        .wr_addr_i  (bus.cfg_addr),
        .wr_entry_i (wr_entry),
        .rd_addr_i  (rd_addr),
        .rd_entry_o (rd_entry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CTX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CTX_IDLE, CTX_DONE: begin
                if (bus.abort)     state_d = CTX_IDLE;
                else if (start_ok) state_d = CTX_RUN;
            end
            CTX_RUN: begin
                if (bus.abort)       state_d = CTX_IDLE;
                else if (final_wrap) state_d = CTX_DONE;
            end
            default: state_d = CTX_IDLE;
        endcase
    end

    always_comb begin
        bus.busy          = (state_q == CTX_RUN);
        bus.alu_enable    = (state_q == CTX_RUN);
        bus.done          = (state_q == CTX_DONE);
        bus.op            = op_q;
        bus.const_data    = const_q;
        bus.context_index = idx_q;
        bus.cfg_error     = err_q;
    end

    always_comb begin
        idx_d   = idx_q;
        iter_d  = iter_q;
        nctx_d  = nctx_q;
        niter_d = niter_q;
        op_d    = op_q;
        const_d = const_q;
        if (bus.abort) begin
            idx_d   = '0;
            iter_d  = '0;
            op_d    = OP_NOP;
            const_d = '0;
        end else if (start_ok) begin
            idx_d   = '0;
            iter_d  = '0;
            nctx_d  = bus.num_contexts;
            niter_d = bus.num_iterations;
            op_d    = start_entry.op;
            const_d = start_entry.const_data;
        end else if (run_switch) begin
            if (final_wrap) begin
                idx_d   = '0;
                iter_d  = iter_inc;
                op_d    = OP_NOP;
                const_d = '0;
            end else begin
                idx_d   = last ? '0 : idx_q + 1'b1;
                iter_d  = wrap ? iter_sat : iter_q;
                op_d    = rd_entry.op;
                const_d = rd_entry.const_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            iter_q  <= '0;
            nctx_q  <= '0;
            niter_q <= '0;
            op_q    <= OP_NOP;
            const_q <= '0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            iter_q  <= iter_d;
            nctx_q  <= nctx_d;
            niter_q <= niter_d;
            op_q    <= op_d;
            const_q <= const_d;
            err_q   <= err_d;
        end
    end

endmodule
